mod_sub_pipe: RTL and testbench



---
 rtl/mod_arith_pkg.sv | 23 ++
 rtl/prefix_carry_core.sv | 40 ++++
 rtl/mod_sub_pipe.sv | 150 +++++++++++++++
 tb/tb_mod_sub_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the residue-arithmetic datapaths.
// Used by the modular subtractor and the modular adder.
package mod_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 7;

    // One in-flight beat: the working difference, the wrap flag, the range error
    // and the K value that was current when the beat was accepted.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] diff;
        logic                     wrap;
        logic                     err;
        logic [DEFAULT_WIDTH-1:0] k;
    } beat_t;

    // Modulus implied by a K encoding: M = 2^n - K.
    function automatic logic [DEFAULT_WIDTH:0] modulus_of(input logic [DEFAULT_WIDTH-1:0] k);
        logic [DEFAULT_WIDTH:0] pow2;
        pow2 = (DEFAULT_WIDTH+1)'(1) << DEFAULT_WIDTH;
        return pow2 - {1'b0, k};
    endfunction

endpackage

// File: rtl/prefix_carry_core.sv
// Combinational n-bit parallel-prefix (Kogge-Stone g/p) adder with carry-in and carry-out.
module prefix_carry_core #(
    parameter int unsigned WIDTH = 7
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] p_cur;
    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0] p_bit;

    // Prefix tree: carry-in is folded into bit 0 so g_cur[i] becomes the carry out of bit i.
    always_comb begin
        p_bit    = a_i ^ b_i;
        g_cur    = a_i & b_i;
        p_cur    = p_bit;
        g_cur[0] = g_cur[0] | (p_cur[0] & cin_i);
        g_nxt    = g_cur;
        p_nxt    = p_cur;
        for (int d = 1; d < int'(WIDTH); d = d * 2) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = d; i < int'(WIDTH); i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-d]);
                p_nxt[i] = p_cur[i] & p_cur[i-d];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        sum_o  = p_bit ^ {g_cur[WIDTH-2:0], cin_i};
        cout_o = g_cur[WIDTH-1];
    end

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor: (A - B) mod (2^n - K) with a valid/ready stream.
// Optional operand range check compiled in with MODSUB_RANGE_CHECK_EN.
module mod_sub_pipe
    import mod_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             k_load,
    input  logic [WIDTH-1:0] k_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             out_wrap,
    output logic             out_err
);

    logic [WIDTH-1:0] k_q, k_d;
    logic             s1_valid_q, s1_valid_d;
    beat_t            s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic             s2_free;
    logic             accept;
    logic [WIDTH-1:0] d0_sum;
    logic             d0_cout;
    logic [WIDTH-1:0] d1_sum;
    logic             d1_cout_unused;
    logic             range_err;

    // D0 = A + ~B + 1; carry-out set means A >= B.
    prefix_carry_core #(.WIDTH(WIDTH)) u_d0 (
        .a_i    (a_in),
        .b_i    (~b_in),
        .cin_i  (1'b1),
        .sum_o  (d0_sum),
        .cout_o (d0_cout)
    );

    // D1 = D0 - K using the K snapshot carried by the stage-1 beat.
    prefix_carry_core #(.WIDTH(WIDTH)) u_d1 (
        .a_i    (s1_q.diff),
        .b_i    (~s1_q.k),
        .cin_i  (1'b1),
        .sum_o  (d1_sum),
        .cout_o (d1_cout_unused)
    );

`ifdef MODSUB_RANGE_CHECK_EN
    logic [WIDTH-1:0] rc_a_sum_unused;
    logic [WIDTH-1:0] rc_b_sum_unused;
    logic             rc_a_cout;
    logic             rc_b_cout;

    // X + K overflows 2^n exactly when X >= M.
    prefix_carry_core #(.WIDTH(WIDTH)) u_rc_a (
        .a_i    (a_in),
        .b_i    (k_q),
        .cin_i  (1'b0),
        .sum_o  (rc_a_sum_unused),
        .cout_o (rc_a_cout)
    );

    prefix_carry_core #(.WIDTH(WIDTH)) u_rc_b (
        .a_i    (b_in),
        .b_i    (k_q),
        .cin_i  (1'b0),
        .sum_o  (rc_b_sum_unused),
        .cout_o (rc_b_cout)
    );

    assign range_err = rc_a_cout | rc_b_cout;
`else
    assign range_err = 1'b0;
`endif

    // Handshake: a stage moves when the stage after it is empty or draining.
    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !k_load && (!s1_valid_q || s2_free);
    assign accept   = in_valid && in_ready;

    // Next-state for K register and both pipeline stages.
    always_comb begin
        k_d        = k_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        wrap_d     = wrap_q;
        err_d      = err_q;

        if (k_load) begin
            k_d = k_in;
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.diff  = d0_sum;
            s1_d.wrap  = ~d0_cout;
            s1_d.err   = range_err;
            s1_d.k     = k_q;
        end else if (s1_valid_q && s2_free) begin
            s1_valid_d = 1'b0;
        end

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = s1_q.wrap ? d1_sum : s1_q.diff;
                wrap_d = s1_q.wrap;
                err_d  = s1_q.err;
            end
        end
    end

    // State registers; reset flushes both stages and restores K = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            k_q        <= k_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff_out  = diff_q;
    assign out_wrap  = wrap_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed bench for mod_sub_pipe (WIDTH = 7).
module tb_mod_sub_pipe;

    localparam int unsigned W = 7;

    logic         clk;
    logic         rst_n;
    logic         k_load;
    logic [W-1:0] k_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff_out;
    logic         out_wrap;
    logic         out_err;

    int n_tests;
    int n_fail;

    typedef struct {
        int k;
        int a;
        int b;
        int diff;
        int wrap;
        int err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    typedef struct {
        int diff;
        int wrap;
    } res_t;
    res_t rq[$];

    mod_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .k_load    (k_load),
        .k_in      (k_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_out  (diff_out),
        .out_wrap  (out_wrap),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: one entry per consumed result beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rq.push_back('{diff: int'(diff_out), wrap: int'(out_wrap)});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_k(input int k);
        tick();
        k_load = 1'b1;
        k_in   = W'(k);
        tick();
        k_load = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int c;
        c = 0;
        while (rq.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    function automatic int exp_err(input int e);
`ifdef MODSUB_RANGE_CHECK_EN
        return e;
`else
        return 0 * e;
`endif
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        k_load    = 1'b0;
        k_in      = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;

        //           k   a    b   diff wrap err
        vecs[0]  = '{20,  69,  45,  24, 0, 0};
        vecs[1]  = '{20,  45,  69,  84, 1, 0};
        vecs[2]  = '{20,   0,   0,   0, 0, 0};
        vecs[3]  = '{20, 107,   0, 107, 0, 0};
        vecs[4]  = '{20,   0, 107,   1, 1, 0};
        vecs[5]  = '{20, 107, 107,   0, 0, 0};
        vecs[6]  = '{20, 110,   3, 107, 0, 1};
        vecs[7]  = '{20, 107,   3, 104, 0, 0};
        vecs[8]  = '{ 0,  45,  69, 104, 1, 0};
        vecs[9]  = '{ 0, 127,   1, 126, 0, 0};
        vecs[10] = '{ 0,   1, 127,   2, 1, 0};
        vecs[11] = '{27,   5, 100,   6, 1, 0};

        // Reset values
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_diff_out", 32'(diff_out), 0);
        check("rst_out_wrap", 32'(out_wrap), 0);
        check("rst_out_err", 32'(out_err), 0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 1);

        // Single-beat vectors with 2-cycle latency check
        for (int i = 0; i < NV; i++) begin
            load_k(vecs[i].k);
            in_valid = 1'b1;
            a_in     = W'(vecs[i].a);
            b_in     = W'(vecs[i].b);
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
            tick();
            in_valid = 1'b0;
            #1;
            check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 0);
            tick();
            #1;
            check($sformatf("v%0d_lat2_valid", i), 32'(out_valid), 1);
            check($sformatf("v%0d_diff", i), 32'(diff_out), 32'(vecs[i].diff));
            check($sformatf("v%0d_wrap", i), 32'(out_wrap), 32'(vecs[i].wrap));
            check($sformatf("v%0d_err", i), 32'(out_err), 32'(exp_err(vecs[i].err)));
        end
        tick();
        tick();

        // Back-pressure: 4 beats, output stalled for the first 4 cycles
        begin
            int  idx;
            logic rdy;
            int  exp_d[4];
            int  exp_w[4];
            exp_d = '{24, 84, 1, 0};
            exp_w = '{0, 1, 1, 0};
            load_k(20);
            rq.delete();
            idx = 0;
            for (int c = 0; c < 30; c++) begin
                out_ready = (c >= 4);
                if (idx < 4) begin
                    in_valid = 1'b1;
                    a_in     = W'(vecs[idx == 0 ? 0 : idx == 1 ? 1 : idx == 2 ? 4 : 5].a);
                    b_in     = W'(vecs[idx == 0 ? 0 : idx == 1 ? 1 : idx == 2 ? 4 : 5].b);
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                rdy = in_ready;
                if (c == 2) begin
                    check("bp_in_ready_full", 32'(in_ready), 0);
                    check("bp_accepts_before_full", 32'(idx), 2);
                    check("bp_valid_held", 32'(out_valid), 1);
                    check("bp_diff_held_c2", 32'(diff_out), 24);
                end
                if (c == 3) begin
                    check("bp_diff_held_c3", 32'(diff_out), 24);
                    check("bp_wrap_held_c3", 32'(out_wrap), 0);
                    check("bp_valid_held_c3", 32'(out_valid), 1);
                end
                if (in_valid && rdy) idx++;
                tick();
                if (idx == 4 && rq.size() == 4) break;
            end
            in_valid = 1'b0;
            check("bp_result_count", 32'(rq.size()), 4);
            for (int j = 0; j < 4; j++) begin
                if (j < rq.size()) begin
                    check($sformatf("bp_r%0d_diff", j), 32'(rq[j].diff), 32'(exp_d[j]));
                    check($sformatf("bp_r%0d_wrap", j), 32'(rq[j].wrap), 32'(exp_w[j]));
                end
            end
        end
        out_ready = 1'b1;
        tick();
        tick();

        // K change while a beat is in flight
        load_k(20);
        rq.delete();
        in_valid = 1'b1;
        a_in     = W'(45);
        b_in     = W'(69);
        #1;
        check("kc_in_ready_b0", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        k_load   = 1'b1;
        k_in     = '0;
        #1;
        check("kc_in_ready_kload", 32'(in_ready), 0);
        tick();
        k_load   = 1'b0;
        in_valid = 1'b1;
        #1;
        check("kc_in_ready_b1", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        wait_results(2, 10);
        tick();
        tick();
        check("kc_result_count", 32'(rq.size()), 2);
        if (rq.size() >= 2) begin
            check("kc_r0_diff", 32'(rq[0].diff), 84);
            check("kc_r0_wrap", 32'(rq[0].wrap), 1);
            check("kc_r1_diff", 32'(rq[1].diff), 104);
            check("kc_r1_wrap", 32'(rq[1].wrap), 1);
        end

        // Reset mid-stream with two beats in flight
        load_k(20);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a_in      = W'(69);
        b_in      = W'(45);
        tick();
        a_in      = W'(45);
        b_in      = W'(69);
        tick();
        in_valid  = 1'b0;
        #1;
        check("rm_valid_before_rst", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rm_valid_async_clear", 32'(out_valid), 0);
        check("rm_diff_async_clear", 32'(diff_out), 0);
        out_ready = 1'b1;
        tick();
        #1;
        rst_n = 1'b1;
        rq.delete();
        for (int c = 0; c < 6; c++) tick();
        check("rm_nothing_emitted", 32'(rq.size()), 0);
        // K restored to 0: (45 - 69) mod 128 = 104
        in_valid = 1'b1;
        a_in     = W'(45);
        b_in     = W'(69);
        tick();
        in_valid = 1'b0;
        wait_results(1, 10);
        check("rm_post_count", 32'(rq.size()), 1);
        if (rq.size() >= 1) begin
            check("rm_k_reset_diff", 32'(rq[0].diff), 104);
            check("rm_k_reset_wrap", 32'(rq[0].wrap), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
